// File: rtl/regfile_bist.sv
// ---------------------------------------------------------------------------
// regfile_bist
//
// Built-in self-test sequencer for the 32x32 register file. When Start is
// accepted it writes the pattern P(i) = DATA_MUL*i + DATA_ADD into registers
// FIRST_REG..LAST_REG, one per cycle. It then reads the range back two
// registers at a time. During the read-back it also issues a guard write with
// RegWrite=0. The guard write targets the register that is read on port A in
// the following cycle, so a register file that ignores its write enable is
// caught. The run ends with a one-cycle Done pulse and a pass/fail result,
// the first failing pointer, and a saturating error count. While Busy is high
// this block owns the register-file port mux.
//
// Ports
//   i_Clk            clock, all state updates on the rising edge
//   i_Rst            synchronous active-high reset
//   i_Start          start request, only looked at in IDLE
//   o_Busy           run in progress (WRITE or CHECK)
//   o_Done           one-cycle pulse at the end of a run
//   o_Pass           result of the last completed run
//   o_FailAddr       pointer at the first mismatch of the last run, 0 if none
//   o_ErrCount       mismatch count of the last run, saturating at 255
//   o_ReadRegister1  register-file read address A
//   o_ReadRegister2  register-file read address B
//   o_WriteRegister  register-file write address
//   o_WriteData      register-file write data
//   o_RegWrite       register-file write enable
//   i_ReadData1      read data A (combinational from o_ReadRegister1)
//   i_ReadData2      read data B (combinational from o_ReadRegister2)
// ---------------------------------------------------------------------------
module regfile_bist #(
  parameter int unsigned FIRST_REG = 8,
  parameter int unsigned LAST_REG  = 26,
  parameter int unsigned DATA_MUL  = 5,
  parameter int unsigned DATA_ADD  = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Pass,
  output logic [4:0]  o_FailAddr,
  output logic [7:0]  o_ErrCount,
  output logic [4:0]  o_ReadRegister1,
  output logic [4:0]  o_ReadRegister2,
  output logic [4:0]  o_WriteRegister,
  output logic [31:0] o_WriteData,
  output logic        o_RegWrite,
  input  logic [31:0] i_ReadData1,
  input  logic [31:0] i_ReadData2
);

  localparam logic [4:0]  FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0]  LAST_ADDR  = 5'(LAST_REG);
  // The last pointer that is compared. The pair at this pointer covers LAST_REG on port B.
  localparam logic [4:0]  LAST_CHECK = 5'(LAST_REG - 1);
  localparam logic [31:0] MUL32      = 32'(DATA_MUL);
  localparam logic [31:0] ADD32      = 32'(DATA_ADD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  // Compute the expected register contents. Wrap-around modulo 2^32 is intended.
  function automatic logic [31:0] pattern(input logic [4:0] idx);
    return MUL32 * {27'd0, idx} + ADD32;
  endfunction

  state_t      r_state;
  logic [4:0]  r_ptr;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_failAddr;
  logic [7:0]  r_errCount;
  logic [4:0]  r_readReg1;
  logic [4:0]  r_readReg2;
  logic [4:0]  r_writeReg;
  logic [31:0] r_writeData;
  logic        r_regWrite;

  state_t      w_stateNext;
  logic [4:0]  w_ptrNext;
  logic        w_busyNext;
  logic        w_doneNext;
  logic        w_passNext;
  logic [4:0]  w_failAddrNext;
  logic [7:0]  w_errCountNext;
  logic [4:0]  w_readReg1Next;
  logic [4:0]  w_readReg2Next;
  logic [4:0]  w_writeRegNext;
  logic [31:0] w_writeDataNext;
  logic        w_regWriteNext;

  logic [4:0]  w_ptrInc;
  logic [4:0]  w_ptrInc2;
  logic        w_misA;
  logic        w_misB;
  logic [8:0]  w_errSum;
  logic [7:0]  w_errSat;

  // Compare the pair that is on the read ports in this cycle. Port A holds r_ptr
  // and port B holds r_ptr+1. Each mismatching port adds one to the error count,
  // and the count saturates at 255.
  always_comb begin
    w_ptrInc  = r_ptr + 5'd1;
    w_ptrInc2 = r_ptr + 5'd2;
    w_misA    = (i_ReadData1 != pattern(r_ptr));
    w_misB    = (i_ReadData2 != pattern(w_ptrInc));
    w_errSum  = {1'b0, r_errCount} + {8'd0, w_misA} + {8'd0, w_misB};
    w_errSat  = w_errSum[8] ? 8'hFF : w_errSum[7:0];
  end

  // Next-state and next-output logic. Every output is registered, so this block
  // computes the value that each output takes after the coming edge. The port
  // outputs default to zero, which covers IDLE and DONE without extra code.
  always_comb begin
    w_stateNext     = r_state;
    w_ptrNext       = r_ptr;
    w_passNext      = r_pass;
    w_failAddrNext  = r_failAddr;
    w_errCountNext  = r_errCount;
    w_busyNext      = 1'b0;
    w_doneNext      = 1'b0;
    w_readReg1Next  = 5'd0;
    w_readReg2Next  = 5'd0;
    w_writeRegNext  = 5'd0;
    w_writeDataNext = 32'd0;
    w_regWriteNext  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          w_stateNext     = S_WRITE;
          w_ptrNext       = FIRST_ADDR;
          w_errCountNext  = 8'd0;
          w_failAddrNext  = 5'd0;
          w_passNext      = 1'b0;
          w_busyNext      = 1'b1;
          w_writeRegNext  = FIRST_ADDR;
          w_writeDataNext = pattern(FIRST_ADDR);
          w_regWriteNext  = 1'b1;
        end
      end

      S_WRITE: begin
        w_busyNext = 1'b1;
        if (r_ptr != LAST_ADDR) begin
          w_ptrNext       = w_ptrInc;
          w_writeRegNext  = w_ptrInc;
          w_writeDataNext = pattern(w_ptrInc);
          w_regWriteNext  = 1'b1;
        end else begin
          // The last write is being committed. Set up the first read pair and
          // its disabled guard write.
          w_stateNext     = S_CHECK;
          w_ptrNext       = FIRST_ADDR;
          w_readReg1Next  = FIRST_ADDR;
          w_readReg2Next  = FIRST_ADDR + 5'd1;
          w_writeRegNext  = FIRST_ADDR + 5'd1;
          w_writeDataNext = ~pattern(FIRST_ADDR + 5'd1);
        end
      end

      S_CHECK: begin
        w_errCountNext = w_errSat;
        // An error count of zero before this edge means no mismatch has
        // been seen yet in this run.
        if ((w_misA || w_misB) && (r_errCount == 8'd0)) begin
          w_failAddrNext = r_ptr;
        end
        if (r_ptr != LAST_CHECK) begin
          w_busyNext      = 1'b1;
          w_ptrNext       = w_ptrInc;
          w_readReg1Next  = w_ptrInc;
          w_readReg2Next  = w_ptrInc2;
          w_writeRegNext  = w_ptrInc2;
          w_writeDataNext = ~pattern(w_ptrInc2);
        end else begin
          w_stateNext = S_DONE;
          w_ptrNext   = 5'd0;
          w_doneNext  = 1'b1;
          w_passNext  = (w_errSat == 8'd0);
        end
      end

      S_DONE: begin
        w_stateNext = S_IDLE;
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and output registers. A reset clears everything at once, including
  // during a run, so no partial result is ever reported.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_failAddr  <= 5'd0;
      r_errCount  <= 8'd0;
      r_readReg1  <= 5'd0;
      r_readReg2  <= 5'd0;
      r_writeReg  <= 5'd0;
      r_writeData <= 32'd0;
      r_regWrite  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_ptr       <= w_ptrNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
      r_pass      <= w_passNext;
      r_failAddr  <= w_failAddrNext;
      r_errCount  <= w_errCountNext;
      r_readReg1  <= w_readReg1Next;
      r_readReg2  <= w_readReg2Next;
      r_writeReg  <= w_writeRegNext;
      r_writeData <= w_writeDataNext;
      r_regWrite  <= w_regWriteNext;
    end
  end

  assign o_Busy          = r_busy;
  assign o_Done          = r_done;
  assign o_Pass          = r_pass;
  assign o_FailAddr      = r_failAddr;
  assign o_ErrCount      = r_errCount;
  assign o_ReadRegister1 = r_readReg1;
  assign o_ReadRegister2 = r_readReg2;
  assign o_WriteRegister = r_writeReg;
  assign o_WriteData     = r_writeData;
  assign o_RegWrite      = r_regWrite;

endmodule
